// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequentially from imem into a small FIFO, flushed on redirect.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_queue #(
  parameter int                XLEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_redirects
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  pc_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_d [DEPTH];
  logic [XLEN-1:0]  instr_mem_q [DEPTH];
  logic [XLEN-1:0]  instr_mem_d [DEPTH];

  logic push;
  logic pop;

  // A redirect overrides both handshakes; a pop frees a slot for the same-cycle push.
  always_comb begin
    pop  = (count_q != '0) && !stall && !redirect_valid;
    push = !redirect_valid && ((count_q < DEPTH_CNT) || pop);
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        fetch_pc_d            = fetch_pc_q + XLEN'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  // Outputs come only from registers and read as zero whenever the queue is empty.
  always_comb begin
    imem_addr    = fetch_pc_q;
    out_valid    = (count_q != '0);
    out_pc       = '0;
    out_instr    = '0;
    out_pc_plus4 = '0;
    if (out_valid) begin
      out_pc       = pc_mem_q[rd_ptr_q];
      out_instr    = instr_mem_q[rd_ptr_q];
      out_pc_plus4 = pc_mem_q[rd_ptr_q] + XLEN'(4);
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = perf_fetched_q + (push ? 32'd1 : 32'd0);
    perf_redirects_d = perf_redirects_q + (redirect_valid ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_redirects = perf_redirects_q;
`else
  assign perf_fetched   = '0;
  assign perf_redirects = '0;
`endif

endmodule
